inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
Parametrised instruction fetch queue for the next-generation, multi-issue core front end. It sits between the IF stage (wide instruction SRAM return, FETCH_W instructions per beat) and ID. It decouples fetch from decode by buffering {pc, inst} pairs in a circular buffer. It accepts up to FETCH_W instructions per cycle, presents up to ISSUE_W in order, and honours the CTRL stall and flush signals.

Parameters:
DEPTH, 8, queue entries; power of 2, must be >= FETCH_W and >= ISSUE_W
FETCH_W, 2, instruction slots per fetch beat (64-bit SRAM return = 2)
ISSUE_W, 2, instructions presented to decode per cycle
CW, $clog2(DEPTH+1), occupancy counter width (derived)
TW, $clog2(ISSUE_W+1), take-count width (derived)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  CTRL flush (exception/eret redirect); empties queue
stall  in  1  CTRL stall for the ID stage; freezes dequeue
in_valid  in  1  fetch beat present
in_pc  in  32  PC of slot 0 of the beat
in_inst  in  FETCH_W*32  instructions; slot i in bits [32i+31:32i]
in_mask  in  FETCH_W  per-slot valid bits
in_ready  out  1  queue can absorb a full beat
out_valid  out  ISSUE_W  out_valid[k] = entry head+k is present
out_pc  out  ISSUE_W*32  PC of presented entry k
out_inst  out  ISSUE_W*32  instruction of presented entry k
out_take  in  TW  number of presented entries decode consumes this cycle
count  out  CW  current occupancy

Behaviour:
- The interface uses one clock and a synchronous, active-high reset, named clk and rst.
- State: DEPTH x {pc[31:0], inst[31:0]} storage, head and tail pointers ($clog2(DEPTH) bits, natural wrap), count[CW-1:0].
- Reset (rst=1 at edge): head=tail=count=0. All storage is cleared to 0. Outputs after reset are out_valid=0, out_pc=0, out_inst=0, count=0 and in_ready=1.
- in_ready = ((DEPTH - count) >= FETCH_W). It is derived from registered count only, with no combinational path from out_take or in_*.
- Push occurs when in_valid & in_ready & ~flush.
  - Slots with in_mask[i]=1 are written in ascending i, packed contiguously starting at tail.
  - The PC of slot i is in_pc + 4*i (32-bit wrap), regardless of packing.
  - tail and count advance by popcount(in_mask). A mask of all zeros is a no-op.
  - in_valid while in_ready=0 is dropped. IF must hold the beat and retry.
- Presentation: out_valid[k] = (count > k). out_pc/out_inst[k] read storage[head+k mod DEPTH] combinationally from registers. Lanes with out_valid[k]=0 drive 0.
- Pop occurs when ~stall & ~flush.
  - The effective take is eff = min(out_take, count, ISSUE_W); over-take is clamped, never underflows.
  - head advances by eff.
  - When stall=1, out_take is ignored (eff=0) while push continues.
- Simultaneous push and pop in one cycle: count_next = count + popcount(push) - eff. A slot freed by pop is not reusable in the same cycle because in_ready uses pre-pop count.
- Flush has priority over push, pop and stall. The next state is head=tail=count=0, and the beat on in_* in the flush cycle is discarded. Storage contents are not cleared.
- Reset has priority over flush.
- Latency: an entry pushed at edge N is presented (out_valid) in the cycle after edge N. There is no bypass from in_* to out_*.
- Ordering is strict FIFO; entries never reorder or duplicate.
- count never exceeds DEPTH. If an assertion detects count > DEPTH, or a push with in_ready=0 being accepted, that is a design error.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, out_valid=2'b00, in_ready=1, out_pc=0.
- Fill: 4 beats, in_pc=0xBFC00000, +8, +16, +24, mask=2'b11, out_take=0 -> count=8, in_ready=0. A fifth beat is dropped. out_pc lane0=0xBFC00000, lane1=0xBFC00004.
- Wrap-around with concurrent traffic: steady push 2/cycle and take 2/cycle for 20 cycles starting at 0x80000000 -> PCs presented in strict +4 order across the pointer wrap, and count stays constant.
- Partial mask and clamp: push in_pc=0x1000, mask=2'b10 into an empty queue.
  - Next cycle: out_valid=2'b01, out_pc lane0=0x1004.
  - out_take=2 -> count=0 and head advances by 1 only.
- Stall: count=4, stall=1, out_take=2, push mask=2'b11 -> count=6, and the presented entries are unchanged.
- Flush priority: count=5, flush=1 with simultaneous push and out_take=2 -> next cycle count=0, out_valid=0, in_ready=1. The following beat at 0xBFC00380 is presented first.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// ============================================================================
// Module      : inst_fetch_queue_if
// Description : Fetch-side and decode-side signal bundle of the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_fetch_queue_if #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_tw = $clog2(ISSUE_W + 1);

    logic                   in_valid;
    logic [31:0]            in_pc;
    logic [FETCH_W*32-1:0]  in_inst;
    logic [FETCH_W-1:0]     in_mask;
    logic                   in_ready;
    logic [ISSUE_W-1:0]     out_valid;
    logic [ISSUE_W*32-1:0]  out_pc;
    logic [ISSUE_W*32-1:0]  out_inst;
    logic [c_tw-1:0]        out_take;
    logic [c_cw-1:0]        count;

    modport master (
        output in_valid, in_pc, in_inst, in_mask, out_take,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_mask, out_take,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module      : inst_fetch_queue
// Description : Circular {pc, inst} buffer between wide fetch and multi-issue
//               decode; packs masked fetch slots, presents ISSUE_W in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    input  wire logic         stall,
    inst_fetch_queue_if.slave bus
);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_aw = $clog2(DEPTH);

    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];
    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [c_cw-1:0]  r_count;

    logic             w_ready;
    logic             w_push;
    logic [c_cw-1:0]  w_push_cnt;
    logic [c_cw-1:0]  w_eff;
    logic [c_aw-1:0]  w_slot_addr [FETCH_W];
    logic [c_aw-1:0]  w_tail_next;
    logic [ISSUE_W-1:0]    w_out_valid;
    logic [ISSUE_W*32-1:0] w_out_pc;
    logic [ISSUE_W*32-1:0] w_out_inst;

    // Readiness looks only at registered occupancy, so a slot freed by this
    // cycle's pop cannot be refilled until the next cycle.
    assign w_ready = (c_cw'(DEPTH) - r_count) >= c_cw'(FETCH_W);
    assign w_push  = bus.in_valid & w_ready & ~flush;

    // Masked slots pack contiguously from tail in ascending slot order.
    always_comb begin
        logic [c_aw-1:0] acc;
        acc        = r_tail;
        w_push_cnt = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_slot_addr[i] = acc;
            if (bus.in_mask[i]) begin
                acc        = acc + c_aw'(1);
                w_push_cnt = w_push_cnt + c_cw'(1);
            end
        end
        w_tail_next = acc;
    end

    always_comb begin
        w_eff = '0;
        if (!stall && !flush) begin
            w_eff = c_cw'(bus.out_take);
            if (w_eff > r_count)
                w_eff = r_count;
            if (w_eff > c_cw'(ISSUE_W))
                w_eff = c_cw'(ISSUE_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                r_pc[d]   <= '0;
                r_inst[d] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    if (bus.in_mask[i]) begin
                        r_pc[w_slot_addr[i]]   <= bus.in_pc + 32'(4 * i);
                        r_inst[w_slot_addr[i]] <= bus.in_inst[32*i +: 32];
                    end
                end
                r_tail <= w_tail_next;
            end
            r_head  <= r_head + c_aw'(w_eff);
            r_count <= r_count + (w_push ? w_push_cnt : c_cw'(0)) - w_eff;
        end
    end

    always_comb begin
        logic [c_aw-1:0] idx;
        w_out_valid = '0;
        w_out_pc    = '0;
        w_out_inst  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            idx = r_head + c_aw'(k);
            if (r_count > c_cw'(k)) begin
                w_out_valid[k]        = 1'b1;
                w_out_pc[32*k +: 32]   = r_pc[idx];
                w_out_inst[32*k +: 32] = r_inst[idx];
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.count     = r_count;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = w_out_pc;
    assign bus.out_inst  = w_out_inst;

    always_ff @(posedge clk) begin
        if (!rst)
            assert (r_count <= c_cw'(DEPTH));
    end
endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Table-driven and randomized checks of inst_fetch_queue
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;
    localparam int DEPTH   = 8;
    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;

    logic clk = 1'b0;
    logic rst, flush, stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mq[$];

    inst_fetch_queue_if #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic        s;
        logic        v;
        logic [31:0] pc;
        logic [1:0]  mask;
        logic [1:0]  take;
        logic [3:0]  e_count;
        logic        e_ready;
        logic [1:0]  e_valid;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        int sz;
        sz = mq.size();
        check("count", 64'(bus.count), 64'(sz));
        check("in_ready", 64'(bus.in_ready), 64'((DEPTH - sz) >= FETCH_W));
        for (int k = 0; k < ISSUE_W; k++) begin
            check($sformatf("valid%0d", k), 64'(bus.out_valid[k]), 64'(k < sz));
            check($sformatf("pc%0d", k), 64'(bus.out_pc[32*k +: 32]),
                  (k < sz) ? 64'(mq[k][63:32]) : 64'd0);
            check($sformatf("inst%0d", k), 64'(bus.out_inst[32*k +: 32]),
                  (k < sz) ? 64'(mq[k][31:0]) : 64'd0);
        end
    endtask

    // Applies one cycle of stimulus, advances the model, then compares.
    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [31:0] pc, input logic [63:0] inst,
                        input logic [1:0] mask, input logic [1:0] take);
        int sz, eff;
        rst          = r;
        flush        = f;
        stall        = s;
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        bus.in_mask  = mask;
        bus.out_take = take;
        if (r || f) begin
            mq.delete();
        end else begin
            sz  = mq.size();
            eff = 0;
            if (!s) begin
                eff = int'(take);
                if (eff > sz) eff = sz;
                if (eff > ISSUE_W) eff = ISSUE_W;
            end
            repeat (eff) void'(mq.pop_front());
            if (v && (DEPTH - sz) >= FETCH_W)
                for (int i = 0; i < FETCH_W; i++)
                    if (mask[i]) mq.push_back({pc + 32'(4 * i), inst[32*i +: 32]});
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00000, 2'b11, 2'd0, 4'd2, 1'b1, 2'b11, 32'hBFC00000, 32'hBFC00004};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00008, 2'b11, 2'd0, 4'd4, 1'b1, 2'b11, 32'hBFC00000, 32'hBFC00004};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00010, 2'b11, 2'd0, 4'd6, 1'b1, 2'b11, 32'hBFC00000, 32'hBFC00004};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00018, 2'b11, 2'd0, 4'd8, 1'b0, 2'b11, 32'hBFC00000, 32'hBFC00004};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'hDEAD0000, 2'b11, 2'd0, 4'd8, 1'b0, 2'b11, 32'hBFC00000, 32'hBFC00004};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 2'b00, 2'd2, 4'd6, 1'b1, 2'b11, 32'hBFC00008, 32'hBFC0000C};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h00000100, 2'b11, 2'd2, 4'd8, 1'b0, 2'b11, 32'hBFC00008, 32'hBFC0000C};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h00000200, 2'b11, 2'd2, 4'd0, 1'b1, 2'b00, 32'h00000000, 32'h00000000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h00001000, 2'b10, 2'd0, 4'd1, 1'b1, 2'b01, 32'h00001004, 32'h00000000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 2'b00, 2'd2, 4'd0, 1'b1, 2'b00, 32'h00000000, 32'h00000000};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'hBFC00380, 2'b11, 2'd0, 4'd2, 1'b1, 2'b11, 32'hBFC00380, 32'hBFC00384};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h00002000, 2'b01, 2'd1, 4'd2, 1'b1, 2'b11, 32'hBFC00384, 32'h00002000};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h00003000, 2'b00, 2'd0, 4'd2, 1'b1, 2'b11, 32'hBFC00384, 32'h00002000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 2'b00, 2'd3, 4'd0, 1'b1, 2'b00, 32'h00000000, 32'h00000000};

        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.in_mask = '0; bus.out_take = '0;
        #2;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 2'b00, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 2'b00, 2'd0);
        check("reset_count", 64'(bus.count), 64'd0);
        check("reset_valid", 64'(bus.out_valid), 64'd0);
        check("reset_ready", 64'(bus.in_ready), 64'd1);
        check("reset_pc", 64'(bus.out_pc), 64'd0);

        for (int t = 0; t < 14; t++) begin
            step(1'b0, tbl[t].f, tbl[t].s, tbl[t].v, tbl[t].pc,
                 {~tbl[t].pc, tbl[t].pc ^ 32'hA5A5A5A5}, tbl[t].mask, tbl[t].take);
            check($sformatf("tbl%0d_count", t), 64'(bus.count), 64'(tbl[t].e_count));
            check($sformatf("tbl%0d_ready", t), 64'(bus.in_ready), 64'(tbl[t].e_ready));
            check($sformatf("tbl%0d_valid", t), 64'(bus.out_valid), 64'(tbl[t].e_valid));
            check($sformatf("tbl%0d_pc0", t), 64'(bus.out_pc[31:0]), 64'(tbl[t].e_pc0));
            check($sformatf("tbl%0d_pc1", t), 64'(bus.out_pc[63:32]), 64'(tbl[t].e_pc1));
        end

        // Steady 2-in/2-out traffic across several pointer wraps.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, {32'h11, 32'h10}, 2'b11, 2'd0);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80000008 + 32'(8 * c),
                 {32'(c), 32'(c + 100)}, 2'b11, 2'd2);
            check("wrap_count", 64'(bus.count), 64'd2);
            check("wrap_pc0", 64'(bus.out_pc[31:0]), 64'(32'h80000008 + 32'(8 * c)));
            check("wrap_pc1", 64'(bus.out_pc[63:32]), 64'(32'h8000000C + 32'(8 * c)));
        end

        for (int c = 0; c < 400; c++) begin
            step((c == 200) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 $urandom, {$urandom, $urandom},
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
